// File: rtl/gpr_wport_arb.sv
// Write-back GPR write-port arbiter: shares the single port between LSU retirement
// and a 2-entry FIFO of muldiv results, with starvation forcing and pending-rd reporting.
module gpr_wport_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_valid,
    input  logic        ls_wen,
    input  logic [4:0]  ls_rd,
    input  logic [63:0] ls_data,
    output logic        ls_ready,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [63:0] md_data,
    output logic        md_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_pend,
    output logic        rs2_pend,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [63:0] gpr_wdata,
    output logic [1:0]  fifo_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]  cnt;
    logic        hd;
    logic [1:0]  live;
    logic [4:0]  ent_rd   [2];
    logic [63:0] ent_data [2];
    logic [3:0]  starve_cnt;

    logic        tail;
    logic        ls_w;
    logic        head_present;
    logic        head_live;
    logic        force_md;
    logic        pop_dead;
    logic        grant_md;
    logic        grant_ls;
    logic        pop;
    logic        push;
    logic [1:0]  live_next;

    assign tail         = hd ^ cnt[0];
    assign ls_w         = ls_valid & ls_wen & (ls_rd != 5'd0);
    assign head_present = (cnt != 2'd0);
    assign head_live    = head_present & live[hd];
    assign force_md     = head_live & (starve_cnt == LIMIT);
    assign pop_dead     = head_present & ~live[hd];
    assign grant_md     = force_md | (head_live & ~ls_w);
    assign grant_ls     = ls_w & ~force_md;
    assign pop          = pop_dead | grant_md;

    assign md_ready = (cnt != 2'd2);
    assign push     = md_valid & md_ready & (md_rd != 5'd0);
    assign ls_ready = ~force_md;
    assign fifo_cnt = cnt;

    assign gpr_wen   = rst_n & (grant_md | grant_ls);
    assign gpr_waddr = grant_md ? ent_rd[hd]   : ls_rd;
    assign gpr_wdata = grant_md ? ent_data[hd] : ls_data;

    assign rs1_pend = (rs1 != 5'd0) & ((live[0] & (ent_rd[0] == rs1)) | (live[1] & (ent_rd[1] == rs1)));
    assign rs2_pend = (rs2 != 5'd0) & ((live[0] & (ent_rd[0] == rs2)) | (live[1] & (ent_rd[1] == rs2)));

    // The granted LSU write is younger, so any queued result to the same rd is dropped;
    // empty slots always carry live=0 so the pend compare needs no occupancy check.
    always_comb begin
        live_next = live;
        for (int i = 0; i < 2; i++) begin
            if (grant_ls && live[i] && (ent_rd[i] == ls_rd))
                live_next[i] = 1'b0;
        end
        if (pop)
            live_next[hd] = 1'b0;
        if (push)
            live_next[tail] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            hd         <= 1'b0;
            live       <= 2'b00;
            starve_cnt <= 4'd0;
        end else begin
            cnt  <= cnt + {1'b0, push} - {1'b0, pop};
            hd   <= hd ^ pop;
            live <= live_next;
            if (!head_live || grant_md)
                starve_cnt <= 4'd0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[tail]   <= md_rd;
            ent_data[tail] <= md_data;
        end
    end

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Directed self-checking bench for gpr_wport_arb (STARVE_LIMIT = 4).
module tb_gpr_wport_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ls_valid, ls_wen;
    logic [4:0]  ls_rd;
    logic [63:0] ls_data;
    logic        ls_ready;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [63:0] md_data;
    logic        md_ready;
    logic [4:0]  rs1, rs2;
    logic        rs1_pend, rs2_pend;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [63:0] gpr_wdata;
    logic [1:0]  fifo_cnt;

    int total = 0;
    int bad   = 0;

    gpr_wport_arb #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ls_valid(ls_valid), .ls_wen(ls_wen), .ls_rd(ls_rd), .ls_data(ls_data), .ls_ready(ls_ready),
        .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
        .rs1(rs1), .rs2(rs2), .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ls(input logic v, input logic [4:0] rd, input logic [63:0] d);
        ls_valid = v;
        ls_wen   = v;
        ls_rd    = rd;
        ls_data  = d;
    endtask

    task automatic set_md(input logic v, input logic [4:0] rd, input logic [63:0] d);
        md_valid = v;
        md_rd    = rd;
        md_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_ls(1'b0, 5'd0, 64'd0);
        set_md(1'b0, 5'd0, 64'd0);
        rs1 = 5'd0;
        rs2 = 5'd0;
        step();
        step();
        #1;
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("[TB] FAIL rst_cnt got=%0d want=0", fifo_cnt); end
        total++; if (md_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_md_ready got=%0b want=1", md_ready); end
        total++; if (ls_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ls_ready got=%0b want=1", ls_ready); end
        total++; if (gpr_wen !== 1'b0) begin bad++; $display("[TB] FAIL rst_wen got=%0b want=0", gpr_wen); end
        total++; if ({rs1_pend, rs2_pend} !== 2'b00) begin bad++; $display("[TB] FAIL rst_pend got=%b want=00", {rs1_pend, rs2_pend}); end
        rst_n = 1'b1;
    endtask

    task automatic test_lsu_only();
        step();
        set_ls(1'b1, 5'd5, 64'hAA);
        #1;
        total++; if (gpr_wen !== 1'b1) begin bad++; $display("[TB] FAIL lsu_wen got=%0b want=1", gpr_wen); end
        total++; if (gpr_waddr !== 5'd5) begin bad++; $display("[TB] FAIL lsu_waddr got=%0d want=5", gpr_waddr); end
        total++; if (gpr_wdata !== 64'hAA) begin bad++; $display("[TB] FAIL lsu_wdata got=%0h want=aa", gpr_wdata); end
        total++; if (ls_ready !== 1'b1) begin bad++; $display("[TB] FAIL lsu_ready got=%0b want=1", ls_ready); end
        step();
        set_ls(1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_muldiv();
        step();
        set_md(1'b1, 5'd7, 64'h1234);
        rs1 = 5'd7;
        #1;
        total++; if (gpr_wen !== 1'b0) begin bad++; $display("[TB] FAIL md_no_readthru got=%0b want=0", gpr_wen); end
        total++; if (rs1_pend !== 1'b0) begin bad++; $display("[TB] FAIL md_pend_early got=%0b want=0", rs1_pend); end
        step();
        set_md(1'b0, 5'd0, 64'd0);
        #1;
        total++; if (fifo_cnt !== 2'd1) begin bad++; $display("[TB] FAIL md_cnt1 got=%0d want=1", fifo_cnt); end
        total++; if (rs1_pend !== 1'b1) begin bad++; $display("[TB] FAIL md_pend got=%0b want=1", rs1_pend); end
        total++; if ({gpr_wen, gpr_waddr} !== {1'b1, 5'd7}) begin bad++; $display("[TB] FAIL md_write got=%0b/%0d want=1/7", gpr_wen, gpr_waddr); end
        total++; if (gpr_wdata !== 64'h1234) begin bad++; $display("[TB] FAIL md_wdata got=%0h want=1234", gpr_wdata); end
        step();
        #1;
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("[TB] FAIL md_cnt0 got=%0d want=0", fifo_cnt); end
        total++; if (gpr_wen !== 1'b0) begin bad++; $display("[TB] FAIL md_idle got=%0b want=0", gpr_wen); end
        rs1 = 5'd0;
    endtask

    task automatic test_starvation();
        step();
        set_md(1'b1, 5'd3, 64'h33);
        set_ls(1'b1, 5'd10, 64'hA0);
        #1;
        total++; if (gpr_waddr !== 5'd10) begin bad++; $display("[TB] FAIL st_push_cycle got=%0d want=10", gpr_waddr); end
        step();
        set_md(1'b0, 5'd0, 64'd0);
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (!(gpr_wen === 1'b1 && gpr_waddr === 5'd10 && ls_ready === 1'b1 && fifo_cnt === 2'd1)) begin
                bad++;
                $display("[TB] FAIL st_lsu_%0d got wen=%0b addr=%0d rdy=%0b cnt=%0d want 1/10/1/1", k, gpr_wen, gpr_waddr, ls_ready, fifo_cnt);
            end
            step();
        end
        total++; if (ls_ready !== 1'b0) begin bad++; $display("[TB] FAIL st_force_rdy got=%0b want=0", ls_ready); end
        total++; if ({gpr_wen, gpr_waddr} !== {1'b1, 5'd3}) begin bad++; $display("[TB] FAIL st_force_addr got=%0b/%0d want=1/3", gpr_wen, gpr_waddr); end
        total++; if (gpr_wdata !== 64'h33) begin bad++; $display("[TB] FAIL st_force_data got=%0h want=33", gpr_wdata); end
        step();
        total++; if ({fifo_cnt, ls_ready, gpr_waddr} !== {2'd0, 1'b1, 5'd10}) begin bad++; $display("[TB] FAIL st_after got cnt=%0d rdy=%0b addr=%0d want 0/1/10", fifo_cnt, ls_ready, gpr_waddr); end
        set_ls(1'b0, 5'd0, 64'd0);
    endtask

    task automatic test_full();
        step();
        set_md(1'b1, 5'd11, 64'h11);
        set_ls(1'b1, 5'd20, 64'hF0);
        step();
        set_md(1'b1, 5'd12, 64'h12);
        #1;
        total++; if ({fifo_cnt, md_ready} !== {2'd1, 1'b1}) begin bad++; $display("[TB] FAIL full_c1 got cnt=%0d rdy=%0b want 1/1", fifo_cnt, md_ready); end
        step();
        set_md(1'b1, 5'd13, 64'h13);
        #1;
        total++; if ({fifo_cnt, md_ready} !== {2'd2, 1'b0}) begin bad++; $display("[TB] FAIL full_c2 got cnt=%0d rdy=%0b want 2/0", fifo_cnt, md_ready); end
        step();
        step();
        step();
        total++; if ({ls_ready, gpr_waddr, md_ready} !== {1'b0, 5'd11, 1'b0}) begin bad++; $display("[TB] FAIL full_forceA got rdy=%0b addr=%0d mrdy=%0b want 0/11/0", ls_ready, gpr_waddr, md_ready); end
        step();
        total++; if ({fifo_cnt, md_ready, ls_ready, gpr_waddr} !== {2'd1, 1'b1, 1'b1, 5'd20}) begin bad++; $display("[TB] FAIL full_accC got cnt=%0d mrdy=%0b rdy=%0b addr=%0d want 1/1/1/20", fifo_cnt, md_ready, ls_ready, gpr_waddr); end
        step();
        set_md(1'b0, 5'd0, 64'd0);
        #1;
        total++; if (fifo_cnt !== 2'd2) begin bad++; $display("[TB] FAIL full_c7 got=%0d want=2", fifo_cnt); end
        step();
        total++; if (ls_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_c8 got=%0b want=1", ls_ready); end
        step();
        total++; if (ls_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_c9 got=%0b want=1", ls_ready); end
        step();
        total++; if ({ls_ready, gpr_waddr, gpr_wdata} !== {1'b0, 5'd12, 64'h12}) begin bad++; $display("[TB] FAIL full_forceB got rdy=%0b addr=%0d data=%0h want 0/12/12", ls_ready, gpr_waddr, gpr_wdata); end
        step();
        set_ls(1'b0, 5'd0, 64'd0);
        #1;
        total++; if ({fifo_cnt, gpr_wen, gpr_waddr, gpr_wdata} !== {2'd1, 1'b1, 5'd13, 64'h13}) begin bad++; $display("[TB] FAIL full_drainC got cnt=%0d wen=%0b addr=%0d data=%0h want 1/1/13/13", fifo_cnt, gpr_wen, gpr_waddr, gpr_wdata); end
        step();
        total++; if ({fifo_cnt, gpr_wen} !== {2'd0, 1'b0}) begin bad++; $display("[TB] FAIL full_empty got cnt=%0d wen=%0b want 0/0", fifo_cnt, gpr_wen); end
    endtask

    task automatic test_waw_kill();
        step();
        set_md(1'b1, 5'd9, 64'h99);
        set_ls(1'b1, 5'd4, 64'h44);
        rs1 = 5'd9;
        step();
        set_md(1'b0, 5'd0, 64'd0);
        set_ls(1'b1, 5'd9, 64'h55);
        #1;
        total++; if (rs1_pend !== 1'b1) begin bad++; $display("[TB] FAIL waw_pend_before got=%0b want=1", rs1_pend); end
        total++; if ({gpr_wen, gpr_waddr, gpr_wdata} !== {1'b1, 5'd9, 64'h55}) begin bad++; $display("[TB] FAIL waw_lsu got wen=%0b addr=%0d data=%0h want 1/9/55", gpr_wen, gpr_waddr, gpr_wdata); end
        step();
        set_ls(1'b0, 5'd0, 64'd0);
        #1;
        total++; if (rs1_pend !== 1'b0) begin bad++; $display("[TB] FAIL waw_pend_after got=%0b want=0", rs1_pend); end
        total++; if ({fifo_cnt, gpr_wen} !== {2'd1, 1'b0}) begin bad++; $display("[TB] FAIL waw_dead_pop got cnt=%0d wen=%0b want 1/0", fifo_cnt, gpr_wen); end
        step();
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("[TB] FAIL waw_drained got=%0d want=0", fifo_cnt); end
        rs1 = 5'd0;
    endtask

    task automatic test_back_to_back();
        step();
        set_md(1'b1, 5'd16, 64'h16);
        step();
        set_md(1'b1, 5'd17, 64'h17);
        #1;
        total++; if ({fifo_cnt, gpr_waddr, md_ready} !== {2'd1, 5'd16, 1'b1}) begin bad++; $display("[TB] FAIL b2b_first got cnt=%0d addr=%0d rdy=%0b want 1/16/1", fifo_cnt, gpr_waddr, md_ready); end
        step();
        set_md(1'b0, 5'd0, 64'd0);
        #1;
        total++; if ({fifo_cnt, gpr_wen, gpr_waddr, gpr_wdata} !== {2'd1, 1'b1, 5'd17, 64'h17}) begin bad++; $display("[TB] FAIL b2b_second got cnt=%0d wen=%0b addr=%0d data=%0h want 1/1/17/17", fifo_cnt, gpr_wen, gpr_waddr, gpr_wdata); end
        step();
        total++; if (fifo_cnt !== 2'd0) begin bad++; $display("[TB] FAIL b2b_empty got=%0d want=0", fifo_cnt); end
    endtask

    task automatic test_x0();
        step();
        set_md(1'b1, 5'd0, 64'hDEAD);
        set_ls(1'b1, 5'd0, 64'hBEEF);
        #1;
        total++; if ({md_ready, ls_ready, gpr_wen} !== 3'b110) begin bad++; $display("[TB] FAIL x0_accept got mrdy=%0b rdy=%0b wen=%0b want 1/1/0", md_ready, ls_ready, gpr_wen); end
        step();
        set_md(1'b0, 5'd0, 64'd0);
        set_ls(1'b0, 5'd0, 64'd0);
        #1;
        total++; if ({fifo_cnt, gpr_wen} !== {2'd0, 1'b0}) begin bad++; $display("[TB] FAIL x0_nopush got cnt=%0d wen=%0b want 0/0", fifo_cnt, gpr_wen); end
    endtask

    task automatic test_reset_full();
        step();
        set_md(1'b1, 5'd14, 64'h14);
        set_ls(1'b1, 5'd4, 64'h44);
        step();
        set_md(1'b1, 5'd15, 64'h15);
        step();
        set_md(1'b0, 5'd0, 64'd0);
        rs1 = 5'd14;
        rs2 = 5'd15;
        #1;
        total++; if ({fifo_cnt, rs1_pend, rs2_pend} !== {2'd2, 1'b1, 1'b1}) begin bad++; $display("[TB] FAIL rf_full got cnt=%0d p1=%0b p2=%0b want 2/1/1", fifo_cnt, rs1_pend, rs2_pend); end
        rst_n = 1'b0;
        #1;
        total++; if (gpr_wen !== 1'b0) begin bad++; $display("[TB] FAIL rf_wen_in_reset got=%0b want=0", gpr_wen); end
        step();
        total++; if ({fifo_cnt, md_ready, ls_ready} !== {2'd0, 1'b1, 1'b1}) begin bad++; $display("[TB] FAIL rf_cleared got cnt=%0d mrdy=%0b rdy=%0b want 0/1/1", fifo_cnt, md_ready, ls_ready); end
        total++; if ({rs1_pend, rs2_pend, gpr_wen} !== 3'b000) begin bad++; $display("[TB] FAIL rf_pend got=%b want=000", {rs1_pend, rs2_pend, gpr_wen}); end
        rst_n = 1'b1;
        set_ls(1'b0, 5'd0, 64'd0);
        rs1 = 5'd0;
        rs2 = 5'd0;
        step();
        total++; if ({fifo_cnt, gpr_wen} !== {2'd0, 1'b0}) begin bad++; $display("[TB] FAIL rf_post got cnt=%0d wen=%0b want 0/0", fifo_cnt, gpr_wen); end
    endtask

    initial begin
        test_reset();
        test_lsu_only();
        test_muldiv();
        test_starvation();
        test_full();
        test_waw_kill();
        test_back_to_back();
        test_x0();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_wport_arb.md
# gpr_wport_arb

Arbiter and scheduler for the single GPR write port in the write-back stage. It shares the port between in-order LSU retirement and an out-of-band long-latency multiply/divide unit. Muldiv results are held in a 2-entry FIFO until the port is free. A starvation counter stalls the LSU for one cycle when the FIFO has waited too long. The block also reports pending destination registers for the issue-stage hazard check.

## Interface
- STARVE_LIMIT, 4: cycles a non-empty FIFO may be denied before the LSU is stalled; legal range 1..15.

- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- ls_valid  in  1  LSU stage retiring an instruction (trap already excluded)
- ls_wen  in  1  retiring instruction writes a GPR
- ls_rd  in  5  LSU destination register
- ls_data  in  64  LSU write data
- ls_ready  out  1  LSU retirement accepted this cycle
- md_valid  in  1  muldiv result available
- md_rd  in  5  muldiv destination register
- md_data  in  64  muldiv result
- md_ready  out  1  FIFO can accept a result
- rs1, rs2  in  5  issue-stage source registers
- rs1_pend, rs2_pend  out  1  source matches a live FIFO entry
- gpr_wen  out  1  GPR write enable
- gpr_waddr  out  5  GPR write address
- gpr_wdata  out  64  GPR write data
- fifo_cnt  out  2  occupied FIFO entries, 0..2

## Operation
- **FIFO:** 2 entries, each holding {live, rd, data}.
  - md_ready = (fifo_cnt != 2).
  - Push on md_valid & md_ready. An md_rd==0 result is accepted but not pushed.
- **Signal definitions:**
  - ls_w = ls_valid & ls_wen & (ls_rd != 0).
  - head_live = fifo non-empty & head.live.
  - force = head_live & (starve_cnt == STARVE_LIMIT).
  - ls_ready = ~force.
- **Grant priority, evaluated each cycle:**
  1. Head present and not live (dead): pop it with no port use. The LSU may still be granted in the same cycle.
  2. force: grant the head. The port carries head.rd/head.data; pop. The LSU is stalled.
  3. head_live & ~ls_w: grant the head; pop. ls_valid without a GPR write still retires.
  4. ls_w: grant the LSU. The port carries ls_rd/ls_data.
  5. Otherwise: gpr_wen = 0.
- **WAW kill:** when the LSU is granted, every live FIFO entry with rd == ls_rd is cleared to dead in the same cycle. The LSU write is younger.
- **Starvation counter (starve_cnt, 4 bits):**
  - Cleared when the FIFO has no live head or a live head is popped.
  - Otherwise increments, saturating at STARVE_LIMIT.
- **Pending flags:** rsN_pend = (rsN != 0) & any live entry with rd == rsN. A push in the current cycle is not visible until the next cycle.
- **Push and pop in the same cycle:**
  - At cnt 1, cnt stays 1 and the new entry becomes head.
  - At cnt 2, push is impossible (md_ready = 0).
- **Reset:** the FIFO, live bits and starve_cnt are cleared. In-flight muldiv results not yet accepted are the producer's concern.

## Timing
- No read-through: the earliest port write for a muldiv result is the cycle after it is accepted.
- gpr_* outputs are combinational from FIFO head state and ls_* inputs; the register file samples at the clk edge.
- Latency:
  - An LSU write goes out in the same cycle unless force is asserted.
  - A muldiv result is written no later than STARVE_LIMIT+1 cycles after it reaches the head.
- Handshakes:
  - md_valid/md_rd/md_data must be held stable until md_ready is sampled high.
  - ls_* must be held while ls_ready = 0.
- **Reset values (while rst_n = 0 and the first cycle after):**
  - fifo_cnt = 0.
  - md_ready = 1, ls_ready = 1.
  - rs1_pend = rs2_pend = 0.
  - gpr_wen is forced to 0 while rst_n = 0.

## Test plan
- **LSU only:** ls_valid=1, wen=1, rd=5, data=0xAA, FIFO empty → same cycle gpr_wen=1, waddr=5, wdata=0xAA, ls_ready=1.
- **Muldiv with LSU idle:** push rd=7, data=0x1234 → next cycle gpr_wen=1, waddr=7, wdata=0x1234; fifo_cnt goes 1→0.
- **Starvation, STARVE_LIMIT=4:** FIFO holds rd=3 while LSU writes every cycle →
  - LSU granted for 4 cycles.
  - 5th cycle: ls_ready=0 and x3 is written.
  - starve_cnt returns to 0.
- **Full FIFO:** two pushes while LSU writes continuously → fifo_cnt=2, md_ready=0; a third md_valid is held until the first pop, then accepted.
- **WAW kill:** FIFO holds live rd=9, LSU writes x9=0x55 →
  - Only 0x55 is written to x9.
  - The entry goes dead and rs1=9 pend deasserts the next cycle.
  - The dead entry later pops with gpr_wen=0.
- **x0 and reset:**
  - Muldiv rd=0 → accepted, fifo_cnt stays 0.
  - rst_n=0 with fifo_cnt=2 → next cycle fifo_cnt=0, md_ready=1, pend flags 0, no GPR write.
